// File: rtl/ex_arb_pkg.sv
// Shared types for the Execute-stage result arbiter: the packed result record,
// the requester identity and the ROB age helper.
package ex_arb_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ROB_ID_W  = 7;
    localparam int MAX_WAIT  = 4;
    localparam int PAYLOAD_W = 2 + 3 * WORD_SIZE + 3 + ROB_ID_W;

    typedef struct packed {
        logic [1:0]           instruction_type;
        logic [WORD_SIZE-1:0] pc;
        logic [2:0]           funct3;
        logic [WORD_SIZE-1:0] alu_result;
        logic [WORD_SIZE-1:0] s2;
        logic [ROB_ID_W-1:0]  rob_id;
    } ex_result_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MUL = 1'b1
    } requester_e;

    // Distance from the ROB head; modular subtraction absorbs index wrap-around.
    function automatic logic [ROB_ID_W-1:0] rob_age(input logic [ROB_ID_W-1:0] rob_id,
                                                    input logic [ROB_ID_W-1:0] rob_head);
        return rob_id - rob_head;
    endfunction

endpackage

// File: rtl/rob_age_compare.sv
// Orders two ROB ids by age relative to the ROB head (smaller age = older).
// Purely combinational so other units (e.g. the LSU) can reuse it.
module rob_age_compare #(
    parameter int ROB_ID_W = 7
) (
    input  logic [ROB_ID_W-1:0] i_rob_id_a,
    input  logic [ROB_ID_W-1:0] i_rob_id_b,
    input  logic [ROB_ID_W-1:0] i_rob_head,
    output logic                o_older_is_a,
    output logic                o_equal
);

    logic [ROB_ID_W-1:0] w_age_a;
    logic [ROB_ID_W-1:0] w_age_b;

    assign w_age_a      = i_rob_id_a - i_rob_head;
    assign w_age_b      = i_rob_id_b - i_rob_head;
    assign o_older_is_a = (w_age_a < w_age_b);
    assign o_equal      = (w_age_a == w_age_b);

endmodule

// File: rtl/ex_result_arbiter.sv
// Arbitrates the single E/M pipeline register between the ALU and the MUL/DIV
// unit: oldest-first, round-robin on ties, with a starvation force-grant.
module ex_result_arbiter
    import ex_arb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ROB_ID_W  = 7,
    parameter int MAX_WAIT  = 4,
    parameter int PAYLOAD_W = 2 + 3 * WORD_SIZE + 3 + ROB_ID_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ROB_ID_W-1:0]  rob_head,
    input  logic                 mem_stall,
    input  logic                 alu_valid,
    input  logic [PAYLOAD_W-1:0] alu_payload,
    input  logic                 mul_valid,
    input  logic [PAYLOAD_W-1:0] mul_payload,
    output logic                 alu_stall,
    output logic                 mul_stall,
    output logic [PAYLOAD_W-1:0] em_payload,
    output logic                 em_valid,
    output logic                 em_stall,
    output logic                 grant_mul
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    requester_e  r_last_grant;
    logic [1:0]  w_valid;
    logic [1:0]  w_win;
    logic [1:0]  w_sat;
    logic        w_alu_older;
    logic        w_age_equal;
    logic        w_arbitrate;
    logic        w_grant_any;
    logic        w_grant_mul;

    rob_age_compare #(
        .ROB_ID_W (ROB_ID_W)
    ) u_age_cmp (
        .i_rob_id_a   (alu_payload[ROB_ID_W-1:0]),
        .i_rob_id_b   (mul_payload[ROB_ID_W-1:0]),
        .i_rob_head   (rob_head),
        .o_older_is_a (w_alu_older),
        .o_equal      (w_age_equal)
    );

    // Index 0 = ALU, index 1 = MUL, matching requester_e.
    assign w_valid     = {mul_valid, alu_valid};
    assign w_arbitrate = ~reset & ~flush & ~mem_stall;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_mul = 1'b0;
        if (w_arbitrate) begin
            if (alu_valid && mul_valid) begin
                w_grant_any = 1'b1;
                if (w_sat[0] && w_sat[1]) begin
                    w_grant_mul = (r_last_grant == REQ_ALU);
                end else if (w_sat[0]) begin
                    w_grant_mul = 1'b0;
                end else if (w_sat[1]) begin
                    w_grant_mul = 1'b1;
                end else if (w_age_equal) begin
                    w_grant_mul = (r_last_grant == REQ_ALU);
                end else begin
                    w_grant_mul = ~w_alu_older;
                end
            end else if (alu_valid) begin
                w_grant_any = 1'b1;
            end else if (mul_valid) begin
                w_grant_any = 1'b1;
                w_grant_mul = 1'b1;
            end
        end
    end

    assign w_win = {w_grant_any & w_grant_mul, w_grant_any & ~w_grant_mul};

    always_comb begin
        alu_stall = 1'b0;
        mul_stall = 1'b0;
        // Flushed units discard their own results, so they are never held.
        if (!reset && !flush) begin
            if (mem_stall) begin
                alu_stall = alu_valid;
                mul_stall = mul_valid;
            end else begin
                alu_stall = alu_valid & ~w_win[0];
                mul_stall = mul_valid & ~w_win[1];
            end
        end
    end

    assign em_payload = w_grant_mul ? mul_payload : alu_payload;
    assign em_valid   = w_grant_any;
    assign em_stall   = mem_stall;
    assign grant_mul  = w_grant_mul;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ_MUL;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_mul ? REQ_MUL : REQ_ALU;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wait
            logic [CNT_W-1:0] r_wait_cnt;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_wait_cnt <= '0;
                end else if (!mem_stall) begin
                    if (!w_valid[gi] || w_win[gi]) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_sat[gi] = (r_wait_cnt == CNT_MAX);
        end
    endgenerate

endmodule

// File: tb/tb_ex_result_arbiter.sv
// Directed-vector bench for ex_result_arbiter; expected values are hand-derived.
module tb_ex_result_arbiter;
    import ex_arb_pkg::*;

    localparam logic [4:0] V_IDLE  = 5'b00000;  // {em_valid, grant_mul, alu_stall, mul_stall, em_stall}
    localparam logic [4:0] V_ALU   = 5'b10010;
    localparam logic [4:0] V_MUL   = 5'b11100;
    localparam logic [4:0] V_ALU1  = 5'b10000;
    localparam logic [4:0] V_MUL1  = 5'b11000;
    localparam logic [4:0] V_MSTL2 = 5'b00111;
    localparam logic [4:0] V_MSTLA = 5'b00101;
    localparam logic [4:0] V_EMSTL = 5'b00001;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic [ROB_ID_W-1:0]  rob_head;
    logic                 mem_stall;
    logic                 alu_valid;
    ex_result_t           alu_payload;
    logic                 mul_valid;
    ex_result_t           mul_payload;
    logic                 alu_stall;
    logic                 mul_stall;
    logic [PAYLOAD_W-1:0] em_payload;
    logic                 em_valid;
    logic                 em_stall;
    logic                 grant_mul;
    logic [4:0]           obs;

    int n_cmp = 0;
    int n_err = 0;

    ex_result_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .rob_head    (rob_head),
        .mem_stall   (mem_stall),
        .alu_valid   (alu_valid),
        .alu_payload (alu_payload),
        .mul_valid   (mul_valid),
        .mul_payload (mul_payload),
        .alu_stall   (alu_stall),
        .mul_stall   (mul_stall),
        .em_payload  (em_payload),
        .em_valid    (em_valid),
        .em_stall    (em_stall),
        .grant_mul   (grant_mul)
    );

    assign obs = {em_valid, grant_mul, alu_stall, mul_stall, em_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_result_t mk(input logic [ROB_ID_W-1:0] id, input logic [31:0] seed);
        ex_result_t p;
        p.instruction_type = seed[1:0];
        p.pc               = 32'h0000_1000 + seed;
        p.funct3           = seed[4:2];
        p.alu_result       = seed ^ 32'hA5A5_0000;
        p.s2               = ~seed;
        p.rob_id           = id;
        return p;
    endfunction

    // Inputs change at the falling edge; checks happen 1 ns later.
    task automatic drive(input logic av, input logic [ROB_ID_W-1:0] aid,
                         input logic mv, input logic [ROB_ID_W-1:0] mid,
                         input logic [ROB_ID_W-1:0] head);
        alu_valid   = av;
        mul_valid   = mv;
        alu_payload = mk(aid, 32'h100 + 32'(aid));
        mul_payload = mk(mid, 32'h200 + 32'(mid));
        rob_head    = head;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        reset = 0; flush = 0; mem_stall = 0;
        drive(0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; mem_stall = 0;
        drive(1, 7, 1, 7, 0);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs, V_IDLE);
        end
        next_cycle();
        mem_stall = 1;
        drive(1, 7, 1, 7, 0);
        n_cmp++;
        if (obs !== V_EMSTL) begin
            n_err++;
            $display("FAIL reset_memstall: got %b want %b", obs, V_EMSTL);
        end
        next_cycle();
        idle_cycle();
        $display("test_reset done");
    endtask

    task automatic test_single();
        drive(1, 5, 0, 9, 0);
        n_cmp++;
        if (obs !== V_ALU1) begin
            n_err++;
            $display("FAIL alu_only_ctrl: got %b want %b", obs, V_ALU1);
        end
        n_cmp++;
        if (em_payload !== PAYLOAD_W'(alu_payload)) begin
            n_err++;
            $display("FAIL alu_only_payload: got %h want %h", em_payload, alu_payload);
        end
        next_cycle();
        drive(0, 5, 1, 9, 0);
        n_cmp++;
        if (obs !== V_MUL1) begin
            n_err++;
            $display("FAIL mul_only_ctrl: got %b want %b", obs, V_MUL1);
        end
        n_cmp++;
        if (em_payload !== PAYLOAD_W'(mul_payload)) begin
            n_err++;
            $display("FAIL mul_only_payload: got %h want %h", em_payload, mul_payload);
        end
        next_cycle();
        drive(0, 5, 0, 9, 0);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL none_valid: got %b want %b", obs, V_IDLE);
        end
        next_cycle();
        $display("test_single done");
    endtask

    task automatic test_age();
        idle_cycle();
        drive(1, 10, 1, 3, 0);
        n_cmp++;
        if (obs !== V_MUL) begin
            n_err++;
            $display("FAIL age_mul_older: got %b want %b", obs, V_MUL);
        end
        n_cmp++;
        if (em_payload !== PAYLOAD_W'(mul_payload)) begin
            n_err++;
            $display("FAIL age_payload: got %h want %h", em_payload, mul_payload);
        end
        next_cycle();
        idle_cycle();
        drive(1, 2, 1, 125, 120);
        n_cmp++;
        if (obs !== V_MUL) begin
            n_err++;
            $display("FAIL wrap_head120: got %b want %b", obs, V_MUL);
        end
        next_cycle();
        drive(1, 2, 1, 125, 126);
        n_cmp++;
        if (obs !== V_ALU) begin
            n_err++;
            $display("FAIL wrap_head126: got %b want %b", obs, V_ALU);
        end
        n_cmp++;
        if (em_payload !== PAYLOAD_W'(alu_payload)) begin
            n_err++;
            $display("FAIL wrap_payload: got %h want %h", em_payload, alu_payload);
        end
        next_cycle();
        $display("test_age done");
    endtask

    task automatic test_starvation();
        logic [4:0] exp;
        idle_cycle();
        for (int c = 1; c <= 6; c++) begin
            drive(1, 20, 1, 10, 0);
            exp = (c == 5) ? V_ALU : V_MUL;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        $display("test_starvation done");
    endtask

    task automatic test_mem_stall();
        logic [4:0] exp;
        idle_cycle();
        drive(1, 20, 1, 10, 0);
        next_cycle();
        mem_stall = 1;
        for (int c = 1; c <= 3; c++) begin
            drive(1, 20, 1, 10, 0);
            n_cmp++;
            if (obs !== V_MSTL2) begin
                n_err++;
                $display("FAIL memstall_both%0d: got %b want %b", c, obs, V_MSTL2);
            end
            next_cycle();
        end
        drive(1, 20, 0, 10, 0);
        n_cmp++;
        if (obs !== V_MSTLA) begin
            n_err++;
            $display("FAIL memstall_alu_only: got %b want %b", obs, V_MSTLA);
        end
        next_cycle();
        mem_stall = 0;
        for (int c = 1; c <= 4; c++) begin
            drive(1, 20, 1, 10, 0);
            exp = (c == 4) ? V_ALU : V_MUL;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL memstall_resume%0d: got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        $display("test_mem_stall done");
    endtask

    task automatic test_flush();
        logic [4:0] exp;
        idle_cycle();
        for (int c = 1; c <= 3; c++) begin
            drive(1, 20, 1, 10, 0);
            next_cycle();
        end
        flush = 1;
        drive(1, 20, 1, 10, 0);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL flush_outputs: got %b want %b", obs, V_IDLE);
        end
        next_cycle();
        mem_stall = 1;
        drive(1, 20, 1, 10, 0);
        n_cmp++;
        if (obs !== V_EMSTL) begin
            n_err++;
            $display("FAIL flush_over_memstall: got %b want %b", obs, V_EMSTL);
        end
        next_cycle();
        flush = 0;
        mem_stall = 0;
        for (int c = 1; c <= 5; c++) begin
            drive(1, 20, 1, 10, 0);
            exp = (c == 5) ? V_ALU : V_MUL;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL flush_resume%0d: got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        idle_cycle();
        drive(1, 7, 0, 7, 0);
        next_cycle();
        reset = 1;
        drive(1, 7, 1, 7, 0);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b want %b", obs, V_IDLE);
        end
        next_cycle();
        reset = 0;
        for (int c = 1; c <= 3; c++) begin
            drive(1, 7, 1, 7, 0);
            exp = (c == 2) ? V_MUL : V_ALU;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL tie_rr%0d: got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1; flush = 0; mem_stall = 0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_age();
        test_starvation();
        test_mem_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
